reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_rd_port.sv | 49 ++++
 rtl/reg_file_sb.sv | 113 +++++++++++
 tb/tb_reg_file_sb.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
//   DATA_W_DEF / ADDR_W_DEF / NUM_RD_DEF : default parameter values
//   data_t / addr_t                      : register word / register index at defaults
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_DEF = 2;

    typedef logic [DATA_W_DEF-1:0] data_t;
    typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port of the register file.
// Selects the addressed register, forwards a same-cycle write (bypass),
// and reports the register's reservation with a same-cycle write hiding it.
//   rst_n   : reset (output forced to 0 / not busy while low)
//   rd_addr : register index to read
//   regs    : current register contents
//   busy    : per-register reservation bits
//   wr_en / wr_addr / wr_data : write happening this cycle
//   rd_data : read value, rd_busy : reservation outstanding
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    localparam int DEPTH   = 1 << ADDR_W
) (
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] regs [DEPTH],
    input  logic [DEPTH-1:0]  busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_busy
);

    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic zero_hit;
    logic bypass_hit;

    assign zero_hit   = ZERO_EN && (rd_addr == '0);
    assign bypass_hit = wr_en && (wr_addr == rd_addr);

    // The reset term keeps the bypass path from leaking wr_data while in reset.
    always_comb begin
        rd_data = regs[rd_addr];
        rd_busy = busy[rd_addr] && !bypass_hit;
        if (!rst_n || zero_hit) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end else if (bypass_hit) begin
            rd_data = wr_data;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with a reservation scoreboard.
// Each register carries a busy bit: set by resv_en, cleared by the write that
// produces it, all cleared by flush. busy_cnt tracks how many are set.
//   clk, rst_n (async, active-low)
//   rd_addr / rd_data / rd_busy : NUM_RD packed combinational read ports
//   wr_en / wr_addr / wr_data   : register write
//   resv_en / resv_addr         : reserve a destination register
//   flush                       : clear every reservation
//   busy_cnt                    : registered count of reserved registers
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     resv_en,
    input  logic [ADDR_W-1:0]        resv_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]  busy_reg;
    logic [DEPTH-1:0]  busy_next;
    logic [ADDR_W:0]   busy_cnt_reg;
    logic [ADDR_W:0]   busy_cnt_next;

    logic wr_valid;
    logic resv_valid;
    logic cnt_inc;
    logic cnt_dec;

    // Address 0 neither stores data nor takes reservations when hardwired.
    assign wr_valid   = wr_en   && !(ZERO_EN && (wr_addr   == '0));
    assign resv_valid = resv_en && !(ZERO_EN && (resv_addr == '0));

    genvar gi;

    // Per-register storage and busy next-state. A reservation on the same
    // edge as a write wins, since the reserving instruction is the newer
    // producer; flush overrides both.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs_reg[gi] <= '0;
                end else if (wr_valid && (wr_addr == ADDR_W'(gi))) begin
                    regs_reg[gi] <= wr_data;
                end
            end

            assign busy_next[gi] = flush                                        ? 1'b0 :
                                   (resv_valid && (resv_addr == ADDR_W'(gi)))   ? 1'b1 :
                                   (wr_valid   && (wr_addr   == ADDR_W'(gi)))   ? 1'b0 :
                                   busy_reg[gi];
        end
    endgenerate

    // Incremental count: +1 when a free register gets reserved, -1 when a
    // busy register is written and not simultaneously re-reserved.
    assign cnt_inc = resv_valid && !busy_reg[resv_addr];
    assign cnt_dec = wr_valid && busy_reg[wr_addr] &&
                     !(resv_valid && (resv_addr == wr_addr));

    assign busy_cnt_next = flush ? '0 :
                           busy_cnt_reg + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg     <= '0;
            busy_cnt_reg <= '0;
        end else begin
            busy_reg     <= busy_next;
            busy_cnt_reg <= busy_cnt_next;
        end
    end

    assign busy_cnt = busy_cnt_reg;

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            regfile_rd_port #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .ZERO_REG (ZERO_REG)
            ) u_rd_port (
                .rst_n   (rst_n),
                .rd_addr (rd_addr[gi*ADDR_W +: ADDR_W]),
                .regs    (regs_reg),
                .busy    (busy_reg),
                .wr_en   (wr_en),
                .wr_addr (wr_addr),
                .wr_data (wr_data),
                .rd_data (rd_data[gi*DATA_W +: DATA_W]),
                .rd_busy (rd_busy[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb (default parameters).
// Expected read/busy/count values come from a behavioural model, are queued
// when stimulus is applied and popped when the DUT outputs are sampled.
module tb_reg_file_sb;
    import regfile_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [AW-1:0]  ra [NR];
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]  rd_busy;
    logic           wr_en = 1'b0;
    logic [AW-1:0]  wr_addr = '0;
    logic [DW-1:0]  wr_data = '0;
    logic           resv_en = 1'b0;
    logic [AW-1:0]  resv_addr = '0;
    logic           flush = 1'b0;
    logic [AW:0]    busy_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int n_step  = 0;

    // Behavioural model state
    logic [DW-1:0]    m_regs [DEPTH];
    logic [DEPTH-1:0] m_busy;

    // Scoreboard
    logic [DW-1:0] exp_q [$];
    string         tag_q [$];

    assign rd_addr = {ra[1], ra[0]};

    always #5 clk = ~clk;

    reg_file_sb #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_RD   (NR),
        .ZERO_REG (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .resv_en   (resv_en),
        .resv_addr (resv_addr),
        .flush     (flush),
        .busy_cnt  (busy_cnt)
    );

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (!rst_n || a == '0) return '0;
        if (wr_en && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (!rst_n || a == '0) return 1'b0;
        if (wr_en && wr_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int popcount(input logic [DEPTH-1:0] v);
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
        m_busy = '0;
    endtask

    task automatic model_edge();
        if (!rst_n) return;
        if (wr_en && wr_addr != '0) m_regs[wr_addr] = wr_data;
        if (flush) begin
            m_busy = '0;
        end else begin
            if (wr_en && wr_addr != '0) m_busy[wr_addr] = 1'b0;
            if (resv_en && resv_addr != '0) m_busy[resv_addr] = 1'b1;
        end
    endtask

    // Push expected combinational outputs for every port, then pop and compare.
    task automatic check_ports(input string name);
        for (int k = 0; k < NR; k++) begin
            exp_q.push_back(exp_rd(ra[k]));
            tag_q.push_back($sformatf("%s.rd_data%0d@r%0d", name, k, ra[k]));
            exp_q.push_back(DW'(exp_busy(ra[k])));
            tag_q.push_back($sformatf("%s.rd_busy%0d@r%0d", name, k, ra[k]));
        end
        for (int k = 0; k < NR; k++) begin
            check_eq(tag_q.pop_front(), rd_data[k*DW +: DW], exp_q.pop_front());
            check_eq(tag_q.pop_front(), DW'(rd_busy[k]), exp_q.pop_front());
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step(input string name);
        #2;
        check_ports(name);
        @(posedge clk);
        model_edge();
        exp_q.push_back(DW'(popcount(m_busy)));
        tag_q.push_back({name, ".busy_cnt"});
        #1;
        check_eq(tag_q.pop_front(), DW'(busy_cnt), exp_q.pop_front());
        n_step++;
        $display("[TB] %0d %s rst_n=%0b wr=%0b@%0d=%h resv=%0b@%0d flush=%0b rd=%0d/%0d cnt=%0d",
                 n_step, name, rst_n, wr_en, wr_addr, wr_data, resv_en, resv_addr, flush,
                 ra[0], ra[1], busy_cnt);
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en = 1'b0; resv_en = 1'b0; flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        ra[0] = '0; ra[1] = '0;
        @(negedge clk);

        // Held in reset: writes and reservations must be ignored, reads zero.
        for (int a = 0; a < DEPTH; a++) begin
            ra[0] = AW'(a); ra[1] = AW'(a ^ 5);
            wr_en = 1'b1; wr_addr = AW'(a); wr_data = $urandom();
            resv_en = 1'b1; resv_addr = AW'(a);
            step("in_reset");
        end
        idle();
        rst_n = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            ra[0] = AW'(a); ra[1] = AW'(DEPTH - 1 - a);
            step("post_reset");
        end

        // Write with bypass, then stored value; writes to r0 are dropped.
        ra[0] = 5; ra[1] = 0;
        wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        step("wr_r5_bypass");
        idle(); step("rd_r5");
        wr_en = 1'b1; wr_addr = 0; wr_data = 32'h1234;
        step("wr_r0_bypass");
        idle(); step("rd_r0");

        // Reserve r7 and r9, then write r7.
        ra[0] = 7; ra[1] = 9;
        resv_en = 1'b1; resv_addr = 7; step("resv_r7");
        resv_addr = 9; step("resv_r9");
        idle(); step("busy_7_9");
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'hA5A5_0007;
        step("wr_r7_hides_busy");
        idle(); step("after_wr_r7");

        // Same-edge reservation and write on an already-busy register.
        wr_en = 1'b1; wr_addr = 9; wr_data = 32'h0000_9999;
        resv_en = 1'b1; resv_addr = 9;
        step("resv_wr_r9");
        idle(); step("after_resv_wr_r9");

        // Reserving r0 is ignored.
        ra[0] = 0; resv_en = 1'b1; resv_addr = 0; step("resv_r0");
        idle(); step("after_resv_r0");

        // Fill r1..r31, then flush alongside a reservation and a write.
        for (int a = 1; a < DEPTH; a++) begin
            ra[0] = AW'(a); ra[1] = AW'(a - 1);
            resv_en = 1'b1; resv_addr = AW'(a);
            step("resv_fill");
        end
        idle();
        ra[0] = 4; ra[1] = 3;
        flush = 1'b1; resv_en = 1'b1; resv_addr = 3;
        wr_en = 1'b1; wr_addr = 4; wr_data = 32'h55;
        step("flush");
        idle(); step("after_flush");

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            ra[0] = AW'($urandom_range(0, DEPTH - 1));
            ra[1] = AW'($urandom_range(0, DEPTH - 1));
            wr_en = 1'($urandom_range(0, 1)); wr_addr = AW'($urandom_range(0, DEPTH - 1));
            wr_data = $urandom();
            resv_en = 1'($urandom_range(0, 1)); resv_addr = AW'($urandom_range(0, DEPTH - 1));
            flush = ($urandom_range(0, 15) == 0);
            if (i % 3 == 0) ra[1] = wr_addr;
            step("random");
        end

        // Ensure reserved state and data exist, then reset between edges.
        idle();
        wr_en = 1'b1; wr_addr = 5; wr_data = 32'hCAFE_F00D;
        resv_en = 1'b1; resv_addr = 6;
        step("pre_async_rst");
        idle();
        ra[0] = 5; ra[1] = 6;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_ports("async_rst");
        check_eq("async_rst.busy_cnt", DW'(busy_cnt), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after release processes inputs normally.
        ra[0] = 5; ra[1] = 2;
        wr_en = 1'b1; wr_addr = 2; wr_data = 32'h0BAD_CAFE;
        resv_en = 1'b1; resv_addr = 8;
        step("first_edge_after_rst");
        idle(); ra[1] = 8; step("after_release");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
